// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FWD_ALU = 2'b11;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0]  STALL_CNT_MAX = 3'd7;
    localparam logic [15:0] PERF_MAX      = 16'hFFFF;

endpackage

// File: rtl/fwd_mux.sv
// One ID-stage operand mux: EX ALU result, MEM load data, or register-file value.
module fwd_mux
    import pipe_ctrl_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_res,
    output logic [DATA_W-1:0] op
);

    always_comb begin
        op = reg_data;
        if (sel == FWD_ALU) begin
            op = alu_res;
        end else if (sel == FWD_MEM) begin
            op = mem_res;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush/forwarding controller with stall watchdog.
// Optional performance counters are built when PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hazard_i,
    input  logic              pc_hazard_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic [1:0]        fwd_rs_sel_i,
    input  logic [1:0]        fwd_rt_sel_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] alu_res_ex_i,
    input  logic [DATA_W-1:0] mem_res_m_i,
    output logic              pc_en_o,
    output logic              ifid_en_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic [DATA_W-1:0] rs_op_o,
    output logic [DATA_W-1:0] rt_op_o,
    output logic [2:0]        stall_cnt_o,
    output logic              stall_err_o,
    output logic [15:0]       perf_stall_o,
    output logic [15:0]       perf_flush_o
);

    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [1:0] fcnt_reg, fcnt_next;
    logic       err_reg, err_next;

    logic stl, redirect, stl_active;
    logic pc_en, ifid_en, ifid_flush, idex_bubble;

    assign stl        = hazard_i | pc_hazard_i;
    assign redirect   = branch_taken_i | jump_i;
    assign stl_active = stl & (state_reg != FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            fcnt_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fcnt_reg  <= fcnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        fcnt_next   = fcnt_reg;
        err_next    = err_reg;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        case (state_reg)
            FLUSH: begin
                // ID holds a NOP, so every request is ignored until the flush drains
                ifid_flush = 1'b1;
                cnt_next   = '0;
                if (fcnt_reg == 2'd0) begin
                    state_next = RUN;
                end else begin
                    fcnt_next = fcnt_reg - 2'd1;
                end
            end
            default: begin
                pc_en       = !stl;
                ifid_en     = !hazard_i;
                idex_bubble = hazard_i;
                ifid_flush  = !stl & redirect;
                if (stl) begin
                    // stall wins: the branch operand is not ready yet
                    state_next = STALL;
                    cnt_next   = (cnt_reg == STALL_CNT_MAX) ? STALL_CNT_MAX : cnt_reg + 3'd1;
                    if (32'(cnt_reg) >= MAX_STALL) begin
                        err_next = 1'b1;
                    end
                end else if (redirect) begin
                    state_next = FLUSH;
                    fcnt_next  = FCNT_INIT;
                    cnt_next   = '0;
                end else begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
        endcase

        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    assign pc_en_o       = pc_en;
    assign ifid_en_o     = ifid_en;
    assign ifid_flush_o  = ifid_flush;
    assign idex_bubble_o = idex_bubble;
    assign stall_cnt_o   = cnt_reg;
    assign stall_err_o   = err_reg;

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
        .sel      (fwd_rs_sel_i),
        .reg_data (rs_data_i),
        .alu_res  (alu_res_ex_i),
        .mem_res  (mem_res_m_i),
        .op       (rs_op_o)
    );

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
        .sel      (fwd_rt_sel_i),
        .reg_data (rt_data_i),
        .alu_res  (alu_res_ex_i),
        .mem_res  (mem_res_m_i),
        .op       (rt_op_o)
    );

`ifdef PIPE_STALL_PERF_EN
    logic [15:0] perf_stall_reg, perf_flush_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (stl_active && perf_stall_reg != PERF_MAX) begin
                perf_stall_reg <= perf_stall_reg + 16'd1;
            end
            if (ifid_flush && perf_flush_reg != PERF_MAX) begin
                perf_flush_reg <= perf_flush_reg + 16'd1;
            end
        end
    end

    assign perf_stall_o = perf_stall_reg;
    assign perf_flush_o = perf_flush_reg;
`else
    logic perf_unused;
    assign perf_unused  = stl_active;
    assign perf_stall_o = '0;
    assign perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Table-driven bench for pipe_stall_ctrl (FLUSH_CYCLES = 2, MAX_STALL = 3) with scoreboard queue.
module tb_pipe_stall_ctrl;

    localparam int DATA_W = 10;
    localparam int NVEC   = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hazard_i, pc_hazard_i, branch_taken_i, jump_i;
    logic [1:0]        fwd_rs_sel_i, fwd_rt_sel_i;
    logic [DATA_W-1:0] rs_data_i, rt_data_i, alu_res_ex_i, mem_res_m_i;
    logic              pc_en_o, ifid_en_o, ifid_flush_o, idex_bubble_o;
    logic [DATA_W-1:0] rs_op_o, rt_op_o;
    logic [2:0]        stall_cnt_o;
    logic              stall_err_o;
    logic [15:0]       perf_stall_o, perf_flush_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .DATA_W       (DATA_W),
        .FLUSH_CYCLES (2),
        .MAX_STALL    (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hazard_i       (hazard_i),
        .pc_hazard_i    (pc_hazard_i),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .fwd_rs_sel_i   (fwd_rs_sel_i),
        .fwd_rt_sel_i   (fwd_rt_sel_i),
        .rs_data_i      (rs_data_i),
        .rt_data_i      (rt_data_i),
        .alu_res_ex_i   (alu_res_ex_i),
        .mem_res_m_i    (mem_res_m_i),
        .pc_en_o        (pc_en_o),
        .ifid_en_o      (ifid_en_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .rs_op_o        (rs_op_o),
        .rt_op_o        (rt_op_o),
        .stall_cnt_o    (stall_cnt_o),
        .stall_err_o    (stall_err_o),
        .perf_stall_o   (perf_stall_o),
        .perf_flush_o   (perf_flush_o)
    );

    // inputs of one cycle, Mealy outputs in that cycle, registered state after its edge
    typedef struct {
        logic       h, p, b, j;
        logic       pc, ife, fl, bub;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs [NVEC];
    vec_t exp_q [$];

`ifdef PIPE_STALL_PERF_EN
    localparam logic [15:0] EXP_PERF_STALL = 16'd1;
    localparam logic [15:0] EXP_PERF_FLUSH = 16'd3;
`else
    localparam logic [15:0] EXP_PERF_STALL = 16'd0;
    localparam logic [15:0] EXP_PERF_FLUSH = 16'd0;
`endif

    function automatic vec_t mk(input logic h, p, b, j, pc, ife, fl, bub,
                                input logic [2:0] cnt, input logic err);
        vec_t v;
        v.h = h; v.p = p; v.b = b; v.j = j;
        v.pc = pc; v.ife = ife; v.fl = fl; v.bub = bub;
        v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input int idx);
        chk("rst_pc_en", idx, 16'(pc_en_o), 16'd0);
        chk("rst_ifid_en", idx, 16'(ifid_en_o), 16'd0);
        chk("rst_flush", idx, 16'(ifid_flush_o), 16'd1);
        chk("rst_bubble", idx, 16'(idex_bubble_o), 16'd1);
        chk("rst_cnt", idx, 16'(stall_cnt_o), 16'd0);
        chk("rst_err", idx, 16'(stall_err_o), 16'd0);
    endtask

    task automatic apply(input int idx);
        vec_t e;
        @(negedge clk);
        hazard_i       = vecs[idx].h;
        pc_hazard_i    = vecs[idx].p;
        branch_taken_i = vecs[idx].b;
        jump_i         = vecs[idx].j;
        exp_q.push_back(vecs[idx]);
        #2;
        e = exp_q.pop_front();
        chk("pc_en", idx, 16'(pc_en_o), 16'(e.pc));
        chk("ifid_en", idx, 16'(ifid_en_o), 16'(e.ife));
        chk("ifid_flush", idx, 16'(ifid_flush_o), 16'(e.fl));
        chk("idex_bubble", idx, 16'(idex_bubble_o), 16'(e.bub));
        @(posedge clk);
        #1;
        chk("stall_cnt", idx, 16'(stall_cnt_o), 16'(e.cnt));
        chk("stall_err", idx, 16'(stall_err_o), 16'(e.err));
        $display("vec %0d: h=%0b p=%0b b=%0b j=%0b pc_en=%0b flush=%0b bubble=%0b cnt=%0d err=%0b",
                 idx, e.h, e.p, e.b, e.j, pc_en_o, ifid_flush_o, idex_bubble_o, stall_cnt_o, stall_err_o);
    endtask

    task automatic idle_inputs();
        hazard_i = 0; pc_hazard_i = 0; branch_taken_i = 0; jump_i = 0;
    endtask

    initial begin
        //                h  p  b  j  pc ife fl bub cnt err
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 3'd1, 0); // load-use stall
        vecs[1]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 3'd0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 1, 1, 1, 0, 3'd0, 0); // taken branch
        vecs[3]  = mk(1, 0, 0, 0, 1, 1, 1, 0, 3'd0, 0); // hazard ignored mid-flush
        vecs[4]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 3'd0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 3'd0, 0);
        vecs[6]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 3'd1, 0); // stall beats branch
        vecs[7]  = mk(0, 0, 1, 0, 1, 1, 1, 0, 3'd0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 3'd0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 3'd0, 0);
        vecs[10] = mk(0, 1, 0, 0, 0, 1, 0, 0, 3'd1, 0); // PC-only hold
        vecs[11] = mk(0, 0, 0, 1, 1, 1, 1, 0, 3'd0, 0); // jump out of STALL
        vecs[12] = mk(0, 0, 0, 0, 1, 1, 1, 0, 3'd0, 0);
        vecs[13] = mk(0, 0, 0, 0, 1, 1, 1, 0, 3'd0, 0);
        vecs[14] = mk(0, 0, 0, 0, 1, 1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 5; i++) begin               // watchdog
            vecs[15+i] = mk(1, 0, 0, 0, 0, 0, 0, 1, 3'(i + 1), (i >= 3) ? 1'b1 : 1'b0);
        end
        vecs[20] = mk(0, 0, 0, 0, 1, 1, 0, 0, 3'd0, 1);
        for (int i = 0; i < 8; i++) begin               // counter saturation
            vecs[21+i] = mk(1, 0, 0, 0, 0, 0, 0, 1, (i >= 6) ? 3'd7 : 3'(i + 1), 1);
        end
        vecs[29] = mk(0, 0, 0, 0, 1, 1, 0, 0, 3'd0, 1);

        rst_n = 0;
        idle_inputs();
        fwd_rs_sel_i = 2'b00; fwd_rt_sel_i = 2'b00;
        rs_data_i = '0; rt_data_i = '0; alu_res_ex_i = '0; mem_res_m_i = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk_reset_outputs(i);
            chk("rst_perf_stall", i, perf_stall_o, 16'd0);
            $display("reset cycle %0d: pc_en=%0b flush=%0b bubble=%0b", i, pc_en_o, ifid_flush_o, idex_bubble_o);
        end
        @(negedge clk);
        rst_n = 1;
        #2;
        chk("post_rst_pc_en", 0, 16'(pc_en_o), 16'd1);
        chk("post_rst_flush", 0, 16'(ifid_flush_o), 16'd0);
        chk("post_rst_bubble", 0, 16'(idex_bubble_o), 16'd0);

        for (int i = 0; i < 6; i++) apply(i);
        chk("perf_stall", 0, perf_stall_o, EXP_PERF_STALL);
        chk("perf_flush", 0, perf_flush_o, EXP_PERF_FLUSH);
        $display("perf: stall=%0d flush=%0d", perf_stall_o, perf_flush_o);
        for (int i = 6; i < NVEC; i++) apply(i);

        // synchronous-to-bench reset clears the sticky watchdog
        @(negedge clk);
        rst_n = 0;
        #2;
        chk_reset_outputs(100);
        chk("rst_perf_flush", 100, perf_flush_o, 16'd0);
        @(negedge clk);
        rst_n = 1;
        $display("watchdog reset: err=%0b", stall_err_o);

        // asynchronous reset in the middle of a stall
        @(negedge clk);
        hazard_i = 1;
        @(posedge clk);
        #1;
        chk("async_stall_cnt_pre", 0, 16'(stall_cnt_o), 16'd1);
        #2;
        rst_n = 0;
        #1;
        chk_reset_outputs(200);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        #2;
        chk("async_stall_pc_en", 0, 16'(pc_en_o), 16'd1);
        $display("async reset in STALL: cnt=%0d pc_en=%0b", stall_cnt_o, pc_en_o);

        // asynchronous reset in the middle of a flush
        @(negedge clk);
        branch_taken_i = 1;
        @(posedge clk);
        #1;
        branch_taken_i = 0;
        #1;
        chk("flush_pre_abort", 0, 16'(ifid_flush_o), 16'd1);
        #1;
        rst_n = 0;
        #1;
        chk_reset_outputs(300);
        @(negedge clk);
        rst_n = 1;
        #2;
        chk("flush_aborted", 0, 16'(ifid_flush_o), 16'd0);
        chk("flush_aborted_pc_en", 0, 16'(pc_en_o), 16'd1);
        $display("async reset in FLUSH: flush=%0b", ifid_flush_o);

        // forwarding, exercised while a stall is active
        @(negedge clk);
        hazard_i = 1;
        fwd_rs_sel_i = 2'b11; alu_res_ex_i = 10'h2A5; rs_data_i = 10'h001;
        mem_res_m_i = 10'h0F0; rt_data_i = 10'h3C3;
        #2;
        chk("rs_alu", 0, 16'(rs_op_o), 16'h2A5);
        chk("rt_reg", 0, 16'(rt_op_o), 16'h3C3);
        $display("fwd: rs_sel=11 rs_op=%0h", rs_op_o);
        fwd_rt_sel_i = 2'b10; mem_res_m_i = 10'h155;
        #2;
        chk("rt_mem", 0, 16'(rt_op_o), 16'h155);
        $display("fwd: rt_sel=10 rt_op=%0h", rt_op_o);
        fwd_rs_sel_i = 2'b00; fwd_rt_sel_i = 2'b11;
        #2;
        chk("rs_reg00", 0, 16'(rs_op_o), 16'h001);
        chk("rt_alu", 0, 16'(rt_op_o), 16'h2A5);
        fwd_rs_sel_i = 2'b01; fwd_rt_sel_i = 2'b01;
        #2;
        chk("rs_reg01", 0, 16'(rs_op_o), 16'h001);
        chk("rt_reg01", 0, 16'(rt_op_o), 16'h3C3);
        fwd_rs_sel_i = 2'b10;
        #2;
        chk("rs_mem", 0, 16'(rs_op_o), 16'h155);
        $display("fwd: rs_sel=10 rs_op=%0h", rs_op_o);
        idle_inputs();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
